// File: rtl/risc_ctrl_p.sv
// Multicycle controller for the 16-bit Simple RISC Machine.
// Holds PC, instruction register, data-address register and the control FSM,
// and steers the register-file/ALU datapath through Moore-decoded control ports.
module risc_ctrl_p #(
  parameter int unsigned AW       = 9,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned LINK_REG = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   mem_rdata,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [2:0]    mem_cmd,
  input  logic [15:0]   dp_out,
  input  logic          N,
  input  logic          V,
  input  logic          Z,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          write,
  output logic [1:0]    vsel,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    alu_op,
  output logic [1:0]    shift,
  output logic [15:0]   sximm5,
  output logic [15:0]   sximm8,
  output logic [15:0]   pc_link,
  output logic          halted
);

  localparam logic [2:0] MNone  = 3'b001;
  localparam logic [2:0] MRead  = 3'b010;
  localparam logic [2:0] MWrite = 3'b100;

  localparam logic [4:0] StIf    = 5'd0;
  localparam logic [4:0] StUpd   = 5'd1;
  localparam logic [4:0] StDec   = 5'd2;
  localparam logic [4:0] StGetA  = 5'd3;
  localparam logic [4:0] StGetB  = 5'd4;
  localparam logic [4:0] StExec  = 5'd5;
  localparam logic [4:0] StWb    = 5'd6;
  localparam logic [4:0] StWbImm = 5'd7;
  localparam logic [4:0] StAddr  = 5'd8;
  localparam logic [4:0] StMrd   = 5'd9;
  localparam logic [4:0] StStrRd = 5'd10;
  localparam logic [4:0] StStrC  = 5'd11;
  localparam logic [4:0] StMwr   = 5'd12;
  localparam logic [4:0] StBr    = 5'd13;
  localparam logic [4:0] StLink  = 5'd14;
  localparam logic [4:0] StBrl   = 5'd15;
  localparam logic [4:0] StBx1   = 5'd16;
  localparam logic [4:0] StBx2   = 5'd17;
  localparam logic [4:0] StBx3   = 5'd18;
  localparam logic [4:0] StHalt  = 5'd19;

  logic [4:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic [AW-1:0] daddr_q, daddr_d;

  // Instruction field decode
  logic [2:0] opcode, op_rn, op_rd, op_rm, cond;
  logic [1:0] op;
  logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_ldr, is_str;
  logic is_b, is_bl, is_bx, is_halt;
  logic br_taken;
  logic [AW-1:0] pc_br;
  logic [15:0] sximm5_raw;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign op_rn  = ir_q[10:8];
  assign op_rd  = ir_q[7:5];
  assign op_rm  = ir_q[2:0];
  assign cond   = ir_q[10:8];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_ldr     = (opcode == 3'b011) && (op == 2'b00);
  assign is_str     = (opcode == 3'b100) && (op == 2'b00);
  assign is_b       = (opcode == 3'b001) && (op == 2'b00);
  assign is_bl      = (opcode == 3'b010) && (op == 2'b11);
  assign is_bx      = (opcode == 3'b010) && (op == 2'b00);
  assign is_halt    = (opcode == 3'b111);

  assign sximm5_raw = {{11{ir_q[4]}}, ir_q[4:0]};
  assign sximm8     = {{8{ir_q[7]}}, ir_q[7:0]};
  assign pc_br      = pc_q + sximm8[AW-1:0];
  assign pc_link    = 16'(pc_q);
  assign alu_op     = op;
  assign shift      = is_mov_reg ? ir_q[4:3] : 2'b00;

  // Upper data bits are intentionally ignored when AW < 16
  if (AW < 16) begin : g_unused
    logic unused_dp_hi;
    assign unused_dp_hi = ^dp_out[15:AW];
  end

  // Branch condition evaluation on the registered status flags
  always_comb begin
    br_taken = 1'b0;
    case (cond)
      3'b000:  br_taken = 1'b1;
      3'b001:  br_taken = Z;
      3'b010:  br_taken = ~Z;
      3'b011:  br_taken = (N != V);
      3'b100:  br_taken = (N != V) | Z;
      default: br_taken = 1'b0;
    endcase
  end

  // State, PC, IR and data-address registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIf;
      pc_q    <= AW'(RESET_PC);
      ir_q    <= '0;
      daddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      daddr_q <= daddr_d;
    end
  end

  // Next-state and architectural register updates
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    daddr_d = daddr_q;
    case (state_q)
      StIf: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = StUpd;
        end
      end
      StUpd: begin
        pc_d    = pc_q + AW'(1);
        state_d = StDec;
      end
      StDec: begin
        if (is_mov_imm)   state_d = StWbImm;
        else if (is_halt) state_d = StHalt;
        else if (is_b)    state_d = StBr;
        else if (is_bl)   state_d = StLink;
        else if (is_bx)   state_d = StBx1;
        else              state_d = StGetA;
      end
      StGetA: state_d = StGetB;
      StGetB: state_d = StExec;
      StExec: begin
        if (is_ldr || is_str)                       state_d = StAddr;
        else if ((is_alu && !is_cmp) || is_mov_reg) state_d = StWb;
        else                                        state_d = StIf;
      end
      StWb:    state_d = StIf;
      StWbImm: state_d = StIf;
      StAddr: begin
        daddr_d = dp_out[AW-1:0];
        state_d = is_str ? StStrRd : StMrd;
      end
      StMrd:   if (mem_ready) state_d = StIf;
      StStrRd: state_d = StStrC;
      StStrC:  state_d = StMwr;
      StMwr:   if (mem_ready) state_d = StIf;
      StBr: begin
        if (br_taken) pc_d = pc_br;
        state_d = StIf;
      end
      StLink:  state_d = StBrl;
      StBrl: begin
        pc_d    = pc_br;
        state_d = StIf;
      end
      StBx1:   state_d = StBx2;
      StBx2:   state_d = StBx3;
      StBx3: begin
        pc_d    = dp_out[AW-1:0];
        state_d = StIf;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIf;
    endcase
  end

  // Moore control outputs; everything is held inactive while reset is asserted
  always_comb begin
    mem_addr = pc_q;
    mem_cmd  = MNone;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    vsel     = 2'b00;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    halted   = 1'b0;
    sximm5   = sximm5_raw;
    if (reset) begin
      case (state_q)
        StIf: mem_cmd = MRead;
        StGetA: begin
          readnum = op_rn;
          loada   = 1'b1;
        end
        StGetB: begin
          readnum = is_str ? op_rd : op_rm;
          loadb   = 1'b1;
        end
        StExec: begin
          loadc = 1'b1;
          loads = is_alu;
          asel  = is_mov_reg;
          bsel  = is_ldr | is_str;
        end
        StWb: begin
          writenum = op_rd;
          vsel     = 2'b00;
          write    = 1'b1;
        end
        StWbImm: begin
          writenum = op_rn;
          vsel     = 2'b10;
          write    = 1'b1;
        end
        StMrd: begin
          mem_addr = daddr_q;
          mem_cmd  = MRead;
          writenum = op_rd;
          vsel     = 2'b11;
          write    = mem_ready;
        end
        StStrRd: begin
          readnum = op_rd;
          loadb   = 1'b1;
        end
        // C = 0 + Rd, which becomes the store data
        StStrC: begin
          asel  = 1'b1;
          loadc = 1'b1;
        end
        StMwr: begin
          mem_addr = daddr_q;
          mem_cmd  = MWrite;
        end
        StLink: begin
          writenum = 3'(LINK_REG);
          vsel     = 2'b01;
          write    = 1'b1;
        end
        StBx1: begin
          readnum = op_rd;
          loada   = 1'b1;
        end
        // Pass Rd through the ALU unchanged by adding a zero offset
        StBx2: begin
          bsel   = 1'b1;
          loadc  = 1'b1;
          sximm5 = 16'h0000;
        end
        StHalt: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_ctrl_p.sv
// Directed bench for risc_ctrl_p: a behavioural register file/ALU and a
// memory with programmable read stalls surround the controller.
module tb_risc_ctrl_p;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   mem_rdata;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_cmd;
  logic [15:0]   dp_out;
  logic          N, V, Z;
  logic [2:0]    readnum, writenum;
  logic          write;
  logic [1:0]    vsel;
  logic          loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]    alu_op, shift;
  logic [15:0]   sximm5, sximm8, pc_link;
  logic          halted;

  risc_ctrl_p #(.AW(AW), .RESET_PC(0), .LINK_REG(7)) dut (
    .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_cmd(mem_cmd), .dp_out(dp_out), .N(N), .V(V), .Z(Z),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .alu_op(alu_op), .shift(shift), .sximm5(sximm5), .sximm8(sximm8),
    .pc_link(pc_link), .halted(halted)
  );

  always #5 clk = ~clk;

  // Behavioural datapath
  logic [15:0] regs [0:7];
  logic [15:0] a_q, b_q, c_q;
  logic        n_q, v_q, z_q;
  logic [15:0] wdata_m, rd_m, bsh_m, ain_m, bin_m, alu_m;
  logic        v_m;

  always_comb begin
    case (vsel)
      2'b00:   wdata_m = c_q;
      2'b01:   wdata_m = pc_link;
      2'b10:   wdata_m = sximm8;
      default: wdata_m = mem_rdata;
    endcase
    rd_m = regs[readnum];
    case (shift)
      2'b00:   bsh_m = b_q;
      2'b01:   bsh_m = b_q << 1;
      2'b10:   bsh_m = b_q >> 1;
      default: bsh_m = {b_q[15], b_q[15:1]};
    endcase
    ain_m = asel ? 16'h0000 : a_q;
    bin_m = bsel ? sximm5 : bsh_m;
    v_m   = 1'b0;
    case (alu_op)
      2'b00: begin
        alu_m = ain_m + bin_m;
        v_m   = (ain_m[15] == bin_m[15]) && (alu_m[15] != ain_m[15]);
      end
      2'b01: begin
        alu_m = ain_m - bin_m;
        v_m   = (ain_m[15] != bin_m[15]) && (alu_m[15] != ain_m[15]);
      end
      2'b10:   alu_m = ain_m & bin_m;
      default: alu_m = ~bin_m;
    endcase
  end

  always_ff @(posedge clk) begin
    if (write) regs[writenum] <= wdata_m;
    if (loada) a_q <= rd_m;
    if (loadb) b_q <= rd_m;
    if (loadc) c_q <= alu_m;
    if (loads) begin
      n_q <= alu_m[15];
      v_q <= v_m;
      z_q <= (alu_m == 16'h0000);
    end
  end

  assign dp_out = c_q;
  assign N = n_q;
  assign V = v_q;
  assign Z = z_q;

  // Memory
  logic [15:0] mem [0:511];
  assign mem_rdata = mem[mem_addr];

  int n_checks = 0;
  int n_pass = 0;
  int stall_addr = 1000;
  int stall_n = 0;
  int hold_cnt = 0;
  logic ldr_wb_ok = 1'b0;
  int fetch_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One cycle: choose mem_ready for the coming edge, then observe the bus
  task automatic tick();
    @(negedge clk);
    if (mem_cmd == 3'b010 && int'(mem_addr) == stall_addr && stall_n > 0) begin
      mem_ready = 1'b0;
      stall_n--;
    end else begin
      mem_ready = 1'b1;
    end
    #1;
    if (mem_cmd == 3'b010 && int'(mem_addr) == stall_addr) hold_cnt++;
    if (mem_cmd == 3'b010 && mem_ready) begin
      fetch_log.push_back(int'(mem_addr));
      if (int'(mem_addr) == stall_addr)
        ldr_wb_ok = write && (vsel == 2'b11) && (writenum == 3'd3);
    end
    if (mem_cmd == 3'b100 && mem_ready) mem[mem_addr] = dp_out;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
  endtask

  task automatic start();
    reset = 1'b0;
    mem_ready = 1'b0;
    stall_n = 0;
    stall_addr = 1000;
    hold_cnt = 0;
    ldr_wb_ok = 1'b0;
    fetch_log.delete();
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic run_until_halt(input int budget, input string tag);
    int i = 0;
    while (!halted && i < budget) begin
      tick();
      i++;
    end
    check({tag, "_halted"}, 32'(halted), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset mid-fetch, then program A: MOV R0,#5; MOV R1,#-3; ADD R2,R0,R1; HALT
    clear_mem();
    mem[0] = 16'hD005;
    mem[1] = 16'hD1FD;
    mem[2] = 16'hA041;
    mem[3] = 16'hE000;
    start();
    stall_addr = 1;
    stall_n = 100;
    for (int i = 0; i < 100 && hold_cnt < 2; i++) tick();
    check("stall_cmd", 32'(mem_cmd), 32'h2);
    check("stall_addr", 32'(mem_addr), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_cmd", 32'(mem_cmd), 32'h1);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_strobes", 32'({write, loada, loadb, loadc, loads}), 32'd0);
    check("rst_pc", 32'(pc_link), 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    stall_n = 0;
    stall_addr = 1000;
    fetch_log.delete();
    tick();
    check("first_fetch_cmd", 32'(mem_cmd), 32'h2);
    check("first_fetch_addr", 32'(mem_addr), 32'd0);
    run_until_halt(200, "progA");
    check("progA_r2", 32'(regs[2]), 32'd2);
    check("progA_r1", 32'(regs[1]), 32'hFFFD);
    check("progA_fetches", 32'(fetch_log.size()), 32'd4);
    check("progA_pc", 32'(pc_link), 32'd4);
    repeat (3) tick();
    check("halt_cmd", 32'(mem_cmd), 32'h1);
    check("halt_strobes", 32'({write, loada, loadb, loadc, loads}), 32'd0);

    // LDR with a 3-cycle stall, then STR back at Rn+3
    clear_mem();
    mem[0] = 16'hD005;
    mem[1] = 16'h6062;
    mem[2] = 16'h8063;
    mem[3] = 16'hE000;
    mem[7] = 16'h1234;
    start();
    stall_addr = 7;
    stall_n = 3;
    run_until_halt(300, "ldr");
    check("ldr_hold", 32'(hold_cnt), 32'd4);
    check("ldr_wb", 32'(ldr_wb_ok), 32'd1);
    check("ldr_r3", 32'(regs[3]), 32'h1234);
    check("str_mem", 32'(mem[8]), 32'h1234);

    // CMP R0,R0; BEQ #-2 at address 10: taken loop back to 9
    clear_mem();
    mem[0]  = 16'hD005;
    mem[1]  = 16'h2007;
    mem[9]  = 16'hA800;
    mem[10] = 16'h21FE;
    mem[11] = 16'hE000;
    start();
    for (int i = 0; i < 300 && fetch_log.size() < 5; i++) tick();
    check("beq_t_count", 32'(fetch_log.size()), 32'd5);
    check("b_target", 32'(fetch_log[2]), 32'd9);
    check("beq_taken", 32'(fetch_log[4]), 32'd9);

    // CMP R0,R1 with R1=3: BEQ falls through to 11
    clear_mem();
    mem[0]  = 16'hD005;
    mem[1]  = 16'hD103;
    mem[2]  = 16'h2006;
    mem[9]  = 16'hA801;
    mem[10] = 16'h21FE;
    mem[11] = 16'hE000;
    start();
    run_until_halt(300, "beq_nt");
    check("beq_nt_count", 32'(fetch_log.size()), 32'd6);
    check("beq_not_taken", 32'(fetch_log[5]), 32'd11);

    // BL #3 at 20, then BX R7 at 24
    clear_mem();
    mem[0]  = 16'h2013;
    mem[20] = 16'h5803;
    mem[24] = 16'h40E0;
    mem[21] = 16'hE000;
    start();
    run_until_halt(300, "bl");
    check("bl_link", 32'(regs[7]), 32'd21);
    check("bl_target", 32'(fetch_log[2]), 32'd24);
    check("bx_target", 32'(fetch_log[3]), 32'd21);
    check("bx_pc", 32'(pc_link), 32'd22);

    // PC wrap: branch to 511, B #1 there lands on 1
    clear_mem();
    mem[0]   = 16'h20FE;
    mem[511] = 16'h2001;
    mem[1]   = 16'hE000;
    start();
    run_until_halt(300, "wrap");
    check("wrap_count", 32'(fetch_log.size()), 32'd3);
    check("wrap_top", 32'(fetch_log[1]), 32'd511);
    check("wrap_target", 32'(fetch_log[2]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
